// File: rtl/mem2wb_if.sv
// MEM/WB stage bus: MEM-stage instruction fields, the data-memory read
// response, and the forwarding / register-file write outputs.
interface mem2wb_if;
   logic        ex2mem_valid_ffout;
   logic        ex2mem_wr_reg_ffout;
   logic [4:0]  ex2mem_wr_regindex_ffout;
   logic [31:0] ex2mem_wr_wdata_ffout;
   logic        ex2mem_load_ffout;
   logic [2:0]  ex2mem_funct3_ffout;
   logic [1:0]  ex2mem_addr_lo_ffout;
   logic        dmem_rsp_valid;
   logic [31:0] dmem_rsp_rdata;
   logic        mem_stall;
   logic        load_err;
   logic        mem2wb_wr_reg;
   logic [31:0] mem2wb_wr_wdata;
   logic        mem2wb_wr_reg_ffout;
   logic [4:0]  mem2wb_wr_regindex_ffout;
   logic [31:0] mem2wb_wr_wdata_ffout;
   logic        wb2regfile_wr_reg;
   logic [4:0]  wb2regfile_wr_regindex;
   logic [31:0] wb2regfile_wr_wdata;

   // Pipeline / memory side: drives the MEM-stage fields and the response.
   modport master (
      output ex2mem_valid_ffout, ex2mem_wr_reg_ffout, ex2mem_wr_regindex_ffout,
             ex2mem_wr_wdata_ffout, ex2mem_load_ffout, ex2mem_funct3_ffout,
             ex2mem_addr_lo_ffout, dmem_rsp_valid, dmem_rsp_rdata,
      input  mem_stall, load_err, mem2wb_wr_reg, mem2wb_wr_wdata,
             mem2wb_wr_reg_ffout, mem2wb_wr_regindex_ffout, mem2wb_wr_wdata_ffout,
             wb2regfile_wr_reg, wb2regfile_wr_regindex, wb2regfile_wr_wdata
   );

   // The MEM/WB stage itself.
   modport slave (
      input  ex2mem_valid_ffout, ex2mem_wr_reg_ffout, ex2mem_wr_regindex_ffout,
             ex2mem_wr_wdata_ffout, ex2mem_load_ffout, ex2mem_funct3_ffout,
             ex2mem_addr_lo_ffout, dmem_rsp_valid, dmem_rsp_rdata,
      output mem_stall, load_err, mem2wb_wr_reg, mem2wb_wr_wdata,
             mem2wb_wr_reg_ffout, mem2wb_wr_regindex_ffout, mem2wb_wr_wdata_ffout,
             wb2regfile_wr_reg, wb2regfile_wr_regindex, wb2regfile_wr_wdata
   );
endinterface

// File: rtl/mem2wb_stage.sv
// Memory-to-writeback stage: retires the MEM-stage instruction, formats load
// data, stalls the pipe while a load waits on data memory (with a timeout),
// and registers the result into the WB stage / register-file write port.
module mem2wb_stage #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input logic     clk,
   input logic     cpurst,
   mem2wb_if.slave bus
);
   localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        stall;
   logic        lerr;
   logic        ld;
   logic        retire;
   logic        wr_reg;
   logic [31:0] fmt_data;
   logic [31:0] wr_wdata;
   logic        wr_reg_q;
   logic [4:0]  regindex_q;
   logic [31:0] wdata_q;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign ld = bus.ex2mem_valid_ffout & bus.ex2mem_load_ffout;

   // State register and wait counter; reset abandons any outstanding load.
   always_ff @(posedge clk) begin
      if (cpurst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state, stall and timeout error; the response wins over a timeout
   // that lands in the same cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall   = 1'b0;
      lerr    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ld && !bus.dmem_rsp_valid) begin
               state_d = ST_WAIT;
               cnt_d   = 16'd1;
               stall   = 1'b1;
            end
         end
         ST_WAIT: begin
            if (bus.dmem_rsp_valid) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == TIMEOUT_LIM) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               lerr    = 1'b1;
            end else begin
               stall = 1'b1;
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Lane selection and sign/zero extension of the raw read word; a
   // half-word uses only addr_lo[1] since misalignment is trapped upstream.
   always_comb begin
      byte_sel = bus.dmem_rsp_rdata[7:0];
      case (bus.ex2mem_addr_lo_ffout)
         2'd0:    byte_sel = bus.dmem_rsp_rdata[7:0];
         2'd1:    byte_sel = bus.dmem_rsp_rdata[15:8];
         2'd2:    byte_sel = bus.dmem_rsp_rdata[23:16];
         default: byte_sel = bus.dmem_rsp_rdata[31:24];
      endcase
      half_sel = bus.ex2mem_addr_lo_ffout[1] ? bus.dmem_rsp_rdata[31:16]
                                             : bus.dmem_rsp_rdata[15:0];
      case (bus.ex2mem_funct3_ffout)
         3'b000:  fmt_data = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  fmt_data = {{16{half_sel[15]}}, half_sel};
         3'b100:  fmt_data = {24'd0, byte_sel};
         3'b101:  fmt_data = {16'd0, half_sel};
         default: fmt_data = bus.dmem_rsp_rdata;
      endcase
   end

   // Retire/forwarding: never forward while stalled; a timed-out load
   // writes zero.
   always_comb begin
      retire = bus.ex2mem_valid_ffout & ~stall;
      wr_reg = retire & bus.ex2mem_wr_reg_ffout & (bus.ex2mem_wr_regindex_ffout != 5'd0);
      if (!bus.ex2mem_load_ffout) begin
         wr_wdata = bus.ex2mem_wr_wdata_ffout;
      end else if (lerr) begin
         wr_wdata = 32'd0;
      end else begin
         wr_wdata = fmt_data;
      end
   end

   // MEM->WB pipeline register; a stall cycle becomes a bubble in WB.
   always_ff @(posedge clk) begin
      if (cpurst) begin
         wr_reg_q   <= 1'b0;
         regindex_q <= '0;
         wdata_q    <= '0;
      end else begin
         wr_reg_q   <= wr_reg;
         regindex_q <= bus.ex2mem_wr_regindex_ffout;
         wdata_q    <= wr_wdata;
      end
   end

   assign bus.mem_stall                = stall;
   assign bus.load_err                 = lerr;
   assign bus.mem2wb_wr_reg            = wr_reg;
   assign bus.mem2wb_wr_wdata          = wr_wdata;
   assign bus.mem2wb_wr_reg_ffout      = wr_reg_q;
   assign bus.mem2wb_wr_regindex_ffout = regindex_q;
   assign bus.mem2wb_wr_wdata_ffout    = wdata_q;
   assign bus.wb2regfile_wr_reg        = wr_reg_q;
   assign bus.wb2regfile_wr_regindex   = regindex_q;
   assign bus.wb2regfile_wr_wdata      = wdata_q;
endmodule

// File: doc/mem2wb_stage.md
Name: mem2wb_stage

Overview:
- Memory-to-writeback pipeline stage.
- Retires the instruction held in the MEM stage and formats load data (byte/half/word, signed/unsigned).
- Stalls upstream while a load waits for a variable-latency data-memory response.
- Drives the MEM-stage and WB-stage forwarding signals consumed by the register file / bypass logic, plus the register-file write port. The WB write port is the registered MEM result.

Parameters:
TIMEOUT_CYCLES, 255, max cycles a load may wait for dmem_rsp_valid before forced completion with error (1..65535)

Ports:
clk  input  1  clock, all state on rising edge
cpurst  input  1  synchronous active-high reset
ex2mem_valid_ffout  input  1  MEM stage holds a valid instruction
ex2mem_wr_reg_ffout  input  1  instruction writes rd
ex2mem_wr_regindex_ffout  input  5  rd index of MEM-stage instruction
ex2mem_wr_wdata_ffout  input  32  ALU result (non-load write data)
ex2mem_load_ffout  input  1  instruction is a load
ex2mem_funct3_ffout  input  3  load size/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
ex2mem_addr_lo_ffout  input  2  load address bits [1:0]
dmem_rsp_valid  input  1  data-memory read response valid (1-cycle pulse)
dmem_rsp_rdata  input  32  raw aligned 32-bit read word
mem_stall  output  1  hold IF/DE/EX/MEM registers this cycle
load_err  output  1  1-cycle pulse: load timed out
mem2wb_wr_reg  output  1  MEM stage retires with rd write this cycle (combinational)
mem2wb_wr_wdata  output  32  formatted write data of retiring MEM instruction (combinational)
mem2wb_wr_reg_ffout  output  1  registered mem2wb_wr_reg (WB stage)
mem2wb_wr_regindex_ffout  output  5  registered rd index (WB stage)
mem2wb_wr_wdata_ffout  output  32  registered write data (WB stage)
wb2regfile_wr_reg  output  1  regfile write enable = mem2wb_wr_reg_ffout
wb2regfile_wr_regindex  output  5  = mem2wb_wr_regindex_ffout
wb2regfile_wr_wdata  output  32  = mem2wb_wr_wdata_ffout

Behaviour:
- Reset (cpurst=1 at posedge): state=IDLE, wait counter=0, all *_ffout outputs=0, load_err=0. Combinational outputs then follow inputs with state IDLE. Reset mid-wait abandons the load; a late dmem_rsp_valid is ignored.
- FSM states:
  - IDLE: no load outstanding.
  - WAIT: load outstanding.
- ld = ex2mem_valid_ffout & ex2mem_load_ffout.
- IDLE transitions:
  - ld & !dmem_rsp_valid -> WAIT; counter=1; mem_stall=1.
  - ld & dmem_rsp_valid -> zero-wait completion, stay IDLE.
  - Non-load -> retire immediately.
- WAIT transitions:
  - mem_stall=1 until dmem_rsp_valid or counter==TIMEOUT_CYCLES.
  - On response: retire with formatted data, mem_stall=0, -> IDLE.
  - On timeout: retire with data 0, load_err=1 for that cycle, mem_stall=0, -> IDLE.
  - Otherwise counter increments.
- dmem_rsp_valid with no load outstanding is ignored.
- Retire condition: retire = ex2mem_valid_ffout & !mem_stall.
  - mem2wb_wr_reg = retire & ex2mem_wr_reg_ffout & (ex2mem_wr_regindex_ffout != 0).
  - mem2wb_wr_reg=0 whenever mem_stall=1, so no stale load data is forwarded.
- Load formatting from dmem_rsp_rdata:
  - Byte lane = addr_lo: 0 -> [7:0], 1 -> [15:8], 2 -> [23:16], 3 -> [31:24].
  - Half lane = addr_lo[1]: 0 -> [15:0], 1 -> [31:16]; addr_lo[0] ignored (misalignment trapped upstream).
  - lb/lh sign-extend; lbu/lhu zero-extend; lw and any other funct3 pass the full word.
  - Non-load: mem2wb_wr_wdata = ex2mem_wr_wdata_ffout.
- Pipeline register, every non-reset posedge:
  - mem2wb_wr_reg_ffout <= mem2wb_wr_reg.
  - mem2wb_wr_regindex_ffout <= ex2mem_wr_regindex_ffout.
  - mem2wb_wr_wdata_ffout <= mem2wb_wr_wdata.
  - A stall cycle therefore inserts a bubble (wr_reg_ffout=0) into WB.
- Latency: non-load and zero-wait load 1 cycle MEM->WB; a load with N wait cycles stalls N cycles.
- wb2regfile_* are pure wires of the *_ffout registers, so WB-stage forwarding equals the value written that cycle.

Test Plan:
- Non-load: valid, wr_reg=1, rd=5, wdata=0x1234_5678 -> same cycle mem2wb_wr_reg=1, wdata=0x12345678; next cycle wb2regfile_wr_reg=1, index=5, data=0x12345678; mem_stall never asserted.
- Byte/half formats: rdata=0x80F1_7F82 with (lb,addr 0) -> 0xFFFF_FF82; (lbu,addr 3) -> 0x0000_0080; (lh,addr 2) -> 0xFFFF_80F1; (lhu,addr 0) -> 0x0000_7F82; (lw) -> 0x80F17F82.
- Wait-state load, rd=7: rsp arrives 3 cycles after load enters MEM -> mem_stall=1 for exactly 3 cycles, mem2wb_wr_reg=0 during stall, WB bubbles, data written to x7 one cycle after the response.
- Timeout with TIMEOUT_CYCLES=4, no response -> mem_stall high 4 cycles, load_err 1-cycle pulse, x-rd written 0, FSM returns IDLE; a response arriving afterwards is ignored.
- rd=0 and spurious rsp: load to x0 completes with mem2wb_wr_reg=0; dmem_rsp_valid pulse in IDLE with no load causes no output change.
- Reset mid-wait: cpurst asserted in cycle 2 of WAIT -> next cycle mem_stall=0, all *_ffout=0, state IDLE, counter 0.
